motor_pwm_driver: RTL
=====================

# motor_pwm_driver

- Downstream stage of the balance PD controller.
- Takes the signed 16-bit balance PWM command and clamps it to a safe magnitude.
- Converts it into a fixed-frequency PWM waveform plus two direction lines for an H-bridge (TB6612-style AIN1/AIN2/PWMA).
- Updates duty only at period boundaries (glitch-free) and inserts coast periods on every direction reversal to protect the bridge.

## Interface
Parameters:
- PERIOD, 1000, clk cycles per PWM period; valid range 2..32767.
- LIMIT, 900, maximum duty magnitude; requires 0 < LIMIT ≤ PERIOD.
- DEAD_PERIODS, 1, whole PWM periods of coast inserted on direction reversal; valid range 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pwm_in  in  16  signed duty command from the balance controller; two's complement.
- en  in  1  drive enable; 0 forces coast.
- pwm_out  out  1  PWM to bridge enable pin.
- ain1  out  1  bridge direction A; 1 = forward.
- ain2  out  1  bridge direction B; 1 = reverse.
- duty  out  16  unsigned magnitude currently applied.
- sat  out  1  high for the period in which the applied command was clamped.
- period_start  out  1  one-cycle pulse on the first cycle of each period (cnt==0).

## Operation
- Counter cnt (16 bit) runs 0..PERIOD-1 and wraps to 0. It runs whenever rst=0, regardless of en.
- Boundary event: cycle where cnt==PERIOD-1. All state, duty, direction and sat updates happen only on this edge, except for rst and en.
- Saturation on the boundary sample:
  - mag = |pwm_in|. Compute in 17 bits so that -32768 gives 32768.
  - If mag > LIMIT, use LIMIT and set sat=1; otherwise use mag and set sat=0.
- Sign rule: sgn = pwm_in[15]. Zero input gives requested direction NONE.
- FSM states:
  - IDLE:
    - Outputs: duty=0, ain1=ain2=0.
    - At a boundary with en=1: go to RUN, load command (no dead time from IDLE).
  - RUN:
    - At a boundary, if the requested direction is opposite to the applied direction (FWD↔REV) and DEAD_PERIODS>0: go to DEAD, dead_cnt=DEAD_PERIODS, duty=0, ain1=ain2=0.
    - Otherwise load the new command and direction. FWD: ain1=1,ain2=0. REV: ain1=0,ain2=1. NONE: both 0, duty=0.
  - DEAD:
    - Outputs: coast.
    - At each boundary, decrement dead_cnt. When it reaches 0 at a boundary, load the command sampled at that same boundary and go to RUN.
    - If that command is again a reversal relative to the pre-DEAD direction, it is still applied directly; no second dead time.
  - Any state with en=0: on the next clock, go to IDLE, duty=0, pwm_out=0, ain1=ain2=0, sat=0.
- pwm_out register: pwm_out <= (state==RUN) && (cnt < duty).
- duty=LIMIT=PERIOD gives a continuous high output.

## Timing
- Reset values: cnt=0, state IDLE, pwm_out=0, ain1=0, ain2=0, duty=0, sat=0, period_start=0. The first period_start pulse comes on the cycle after rst deasserts (cnt==0).
- Latency from a pwm_in change to the applied duty:
  - Sampled only on boundary cycles.
  - Applied duty/ain change on the first cycle of the next period.
  - pwm_out follows one cycle later (registered compare).
- Within a period, pwm_out is high for exactly duty consecutive cycles. Changes to pwm_in mid-period have no effect.
- ain1 and ain2 are never both 1 in any cycle.
- Reversal with DEAD_PERIODS=D: exactly D full periods of coast, then the new direction is applied.
- en deassertion mid-period: outputs coast on the cycle after en is sampled low.
- en reassertion: drive resumes at the first boundary where en=1.
- rst mid-period overrides everything: values return to reset on the next edge.

## Test plan
- Reset then pwm_in=+300, en=1, PERIOD=1000:
  - Required: pwm_out high 300 cycles per period.
  - Required: ain1=1, ain2=0, sat=0, duty=300.
- pwm_in=-32768:
  - Required: duty=900, sat=1, ain1=0, ain2=1.
  - Required: pwm_out high 900 of 1000 cycles.
- Reversal, DEAD_PERIODS=1: +500 steady, then pwm_in=-200 mid-period.
  - Required: remainder of that period keeps 500 forward.
  - Required: next period is coast (both ain 0, pwm_out 0).
  - Required: following period is reverse with 200 high cycles.
- pwm_in changed every cycle with random values:
  - Required: duty changes only on period_start cycles.
  - Required: high count equals the clamped magnitude sampled at cnt==999.
  - Required: ain1&ain2 never 1.
- en dropped at cnt=100 while duty=600:
  - Required: pwm_out=0 and ain=00 from cnt=101.
  - en raised at cnt=400: drive resumes at the next cnt==0.
- pwm_in=0 and rst asserted mid-period:
  - pwm_in=0 required: coast, duty=0.
  - rst pulse required: all outputs at reset values next cycle.
  - After rst release: cnt restarts at 0.

Source files
------------

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
// Turns the signed balance-controller command into an H-bridge drive: a fixed-frequency
// PWM waveform plus two direction lines (TB6612-style AIN1/AIN2/PWMA). The command is
// clamped to LIMIT and sampled only on the last cycle of each PWM period, so duty and
// direction change cleanly at period boundaries. A direction reversal inserts DEAD_PERIODS
// whole periods of coast before the new direction is driven.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   pwm_in       signed duty command (two's complement)
//   en           drive enable; low forces coast on the next clock
//   pwm_out      PWM to the bridge enable pin (registered compare)
//   ain1 / ain2  direction lines: ain1 = forward, ain2 = reverse, never both high
//   duty         duty magnitude applied in the current period
//   sat          high for the period whose applied command was clamped
//   period_start one-cycle pulse on the first cycle of each period (cnt == 0)

module motor_pwm_driver #(
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned LIMIT        = 900,
  parameter int unsigned DEAD_PERIODS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] pwm_in,
  input  logic               en,
  output logic               pwm_out,
  output logic               ain1,
  output logic               ain2,
  output logic        [15:0] duty,
  output logic               sat,
  output logic               period_start
);

  localparam logic [15:0] LastCnt  = 16'(PERIOD - 1);
  localparam logic [16:0] Limit17  = 17'(LIMIT);
  localparam logic [15:0] Limit16  = 16'(LIMIT);
  localparam logic [3:0]  DeadInit = 4'(DEAD_PERIODS);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  dead_cnt_q;
  logic        started_q;
  logic        pwm_q;
  logic        ain1_q;
  logic        ain2_q;
  logic [15:0] duty_q;
  logic        sat_q;

  logic        boundary;
  logic [16:0] mag;
  logic        cmd_sat;
  logic [15:0] cmd_duty;
  logic        req_fwd;
  logic        req_rev;
  logic        reversal;
  logic        load_cmd;
  logic        enter_dead;

  // started_q holds cnt at 0 for the first cycle after reset release, so that cycle
  // carries the first period_start pulse.
  assign boundary = started_q && (cnt_q == LastCnt);

  always_comb begin
    // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping.
    mag      = pwm_in[15] ? (17'd0 - {pwm_in[15], pwm_in}) : {1'b0, pwm_in};
    cmd_sat  = (mag > Limit17);
    cmd_duty = cmd_sat ? Limit16 : mag[15:0];
    req_fwd  = ~pwm_in[15] && (pwm_in != 16'sd0);
    req_rev  = pwm_in[15];
    // Reversal is judged against the direction currently driven on the bridge.
    reversal = (req_fwd && ain2_q) || (req_rev && ain1_q);

    load_cmd   = 1'b0;
    enter_dead = 1'b0;
    if (boundary) begin
      case (state_q)
        StIdle: load_cmd = 1'b1;
        StRun: begin
          if (reversal && (DeadInit != 4'd0)) begin
            enter_dead = 1'b1;
          end else begin
            load_cmd = 1'b1;
          end
        end
        // Leaving DEAD applies the fresh sample directly, even if it is another reversal.
        StDead:  load_cmd = (dead_cnt_q <= 4'd1);
        default: load_cmd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dead_cnt_q <= '0;
      started_q  <= 1'b0;
      pwm_q      <= 1'b0;
      ain1_q     <= 1'b0;
      ain2_q     <= 1'b0;
      duty_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (started_q) begin
        cnt_q <= boundary ? 16'd0 : cnt_q + 16'd1;
      end
      pwm_q <= en && (state_q == StRun) && (cnt_q < duty_q);

      if (!en) begin
        state_q    <= StIdle;
        dead_cnt_q <= '0;
        ain1_q     <= 1'b0;
        ain2_q     <= 1'b0;
        duty_q     <= '0;
        sat_q      <= 1'b0;
      end else if (load_cmd) begin
        state_q    <= StRun;
        dead_cnt_q <= '0;
        ain1_q     <= req_fwd;
        ain2_q     <= req_rev;
        duty_q     <= cmd_duty;
        sat_q      <= cmd_sat;
      end else if (enter_dead) begin
        state_q    <= StDead;
        dead_cnt_q <= DeadInit;
        ain1_q     <= 1'b0;
        ain2_q     <= 1'b0;
        duty_q     <= '0;
        sat_q      <= 1'b0;
      end else if (boundary && (state_q == StDead)) begin
        dead_cnt_q <= dead_cnt_q - 4'd1;
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign ain1         = ain1_q;
  assign ain2         = ain2_q;
  assign duty         = duty_q;
  assign sat          = sat_q;
  assign period_start = started_q && (cnt_q == 16'd0);

endmodule
